// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

   localparam int IMEM_DEPTH = 256;   // instruction words held by imem
   localparam int WORD_BYTES = 4;     // bytes per instruction word
   localparam int LEN_BYTES  = 2;     // bytes in the frame length header

   // Loader sequencing: header, payload, trailer, then a sticky outcome.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the boot loader, bundled.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_waddr, imem_wdata
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The completed word is
// presented combinationally alongside the 4th byte so the caller can register
// it at the same edge that accepts that byte.
module imem_word_assembler
   import imem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [23:0] r_shift;
   logic [1:0]  r_cnt;

   // Shift each byte in from the top so the first byte ends up as the LSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_byte_valid) begin
         r_shift <= {i_byte, r_shift[23:8]};
         r_cnt   <= r_cnt + 2'd1;
      end
   end

   // The final byte completes the word without ever entering the shift register.
   always_comb begin
      o_word_valid = i_byte_valid && (r_cnt == 2'(WORD_BYTES - 1));
      o_word       = {i_byte, r_shift};
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes the payload
// words sequentially into imem and keeps the CPU held until a frame has been
// loaded with a matching checksum.
module imem_loader
   import imem_pkg::*;
#(
   parameter int          DEPTH     = IMEM_DEPTH,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   imem_loader_if.slave           bus,
   input  logic                   i_load_start,
   output logic                   o_cpu_hold,
   output logic                   o_load_busy,
   output logic                   o_load_done,
   output logic                   o_load_error,
   output logic [$clog2(DEPTH):0] o_words_written
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   // Low address bits are forced to zero so imem always sees word addresses.
   localparam logic [31:0] BASE_W  = {BASE_ADDR[31:2], 2'b00};

   loader_state_t r_state;
   loader_state_t w_state_next;

   logic          w_rx_ready;
   logic          w_xfer;
   logic          w_start;
   logic [15:0]   w_len_in;
   logic          w_last_word;
   logic          w_word_valid;
   logic [31:0]   w_word;

   logic [7:0]    r_len_l;
   logic [CW-1:0] r_len;
   logic [7:0]    r_csum;
   logic [CW-1:0] r_words_asm;
   logic [CW-1:0] r_words_written;
   logic          r_we;
   logic [31:0]   r_waddr;
   logic [31:0]   r_wdata;

   assign w_xfer      = bus.rx_valid && w_rx_ready;
   assign w_start     = i_load_start &&
                        (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
   assign w_len_in    = {bus.rx_data, r_len_l};
   // Word-count compare uses the assembly counter, which leads the write strobe.
   assign w_last_word = ((r_words_asm + CW'(1)) == r_len);

   imem_word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start),
      .i_byte_valid (w_xfer && (r_state == S_DATA)),
      .i_byte       (bus.rx_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_state_next = r_state;
      w_rx_ready   = 1'b0;
      o_cpu_hold   = (r_state != S_DONE);
      o_load_busy  = 1'b0;
      o_load_done  = (r_state == S_DONE);
      o_load_error = (r_state == S_ERR);
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (i_load_start) w_state_next = S_LEN0;
         end
         S_LEN0: begin
            w_rx_ready  = 1'b1;
            o_load_busy = 1'b1;
            if (w_xfer) w_state_next = S_LEN1;
         end
         S_LEN1: begin
            w_rx_ready  = 1'b1;
            o_load_busy = 1'b1;
            if (w_xfer) begin
               if ({16'd0, w_len_in} > DEPTH_W) w_state_next = S_ERR;
               else if (w_len_in == 16'd0)      w_state_next = S_CSUM;
               else                             w_state_next = S_DATA;
            end
         end
         S_DATA: begin
            w_rx_ready  = 1'b1;
            o_load_busy = 1'b1;
            if (w_word_valid && w_last_word) w_state_next = S_CSUM;
         end
         S_CSUM: begin
            w_rx_ready  = 1'b1;
            o_load_busy = 1'b1;
            if (w_xfer) w_state_next = (bus.rx_data == r_csum) ? S_DONE : S_ERR;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Header capture and running XOR over every byte ahead of the checksum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len_l <= '0;
         r_len   <= '0;
         r_csum  <= '0;
      end else if (w_start) begin
         r_csum  <= '0;
      end else if (w_xfer) begin
         if (r_state == S_LEN0 || r_state == S_LEN1 || r_state == S_DATA)
            r_csum <= r_csum ^ bus.rx_data;
         if (r_state == S_LEN0) r_len_l <= bus.rx_data;
         // Only counts that passed the depth check are ever used downstream.
         if (r_state == S_LEN1) r_len <= w_len_in[CW-1:0];
      end
   end

   // Write port: registered separately from assembly so bytes never stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we            <= 1'b0;
         r_waddr         <= BASE_W;
         r_wdata         <= '0;
         r_words_asm     <= '0;
         r_words_written <= '0;
      end else begin
         r_we <= w_word_valid;
         if (w_start) begin
            r_words_asm     <= '0;
            r_words_written <= '0;
         end else if (w_word_valid) begin
            r_words_asm     <= r_words_asm + CW'(1);
            r_words_written <= r_words_written + CW'(1);
            r_waddr         <= BASE_W + {{(30 - CW){1'b0}}, r_words_written, 2'b00};
            r_wdata         <= w_word;
         end
      end
   end

   assign bus.rx_ready   = w_rx_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_waddr = r_waddr;
   assign bus.imem_wdata = r_wdata;
   assign o_words_written = r_words_written;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists, the
// expected write sequence (address, data, cycle) is derived from the frame
// rules and compared against a monitor of the imem write port.
module tb_imem_loader;
   import imem_pkg::*;

   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_start;
   logic       cpu_hold, load_busy, load_done, load_error;
   logic [8:0] words_written;

   imem_loader_if bus ();

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .i_load_start    (load_start),
      .o_cpu_hold      (cpu_hold),
      .o_load_busy     (load_busy),
      .o_load_done     (load_done),
      .o_load_error    (load_error),
      .o_words_written (words_written)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor of the imem write port, sampled mid-cycle.
   int          wr_cyc[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(bus.imem_waddr);
         wr_data.push_back(bus.imem_wdata);
      end
   end

   // Model state: payload words, the frame built from them, transfer cycles.
   logic [31:0] exp_words[$];
   logic [7:0]  frame[$];
   int          acc_cyc[$];
   int          n_drop;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1);
   end

   // Frame = LEN_L, LEN_H, payload LSB-first, XOR of everything before it.
   task automatic build_frame(input int len, input bit bad);
      logic [15:0] l;
      logic [7:0]  x;
      logic [31:0] w;
      l = len[15:0];
      frame.delete();
      frame.push_back(l[7:0]);
      frame.push_back(l[15:8]);
      foreach (exp_words[k]) begin
         w = exp_words[k];
         for (int b = 0; b < 4; b++) frame.push_back(w[8*b +: 8]);
      end
      x = 8'h00;
      foreach (frame[i]) x = x ^ frame[i];
      frame.push_back(bad ? ~x : x);
   endtask

   task automatic random_words(input int n);
      exp_words.delete();
      for (int k = 0; k < n; k++) exp_words.push_back($urandom);
   endtask

   task automatic do_start();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
   endtask

   // Offer every frame byte once; a byte seen with rx_ready low is dropped.
   // start_at >= 0 raises load_start together with that byte.
   task automatic send_frame(input int gap_pct, input int start_at);
      acc_cyc.delete();
      n_drop = 0;
      foreach (frame[i]) begin
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            load_start   = 1'b0;
         end
         @(negedge clk);
         bus.rx_valid = 1'b1;
         bus.rx_data  = frame[i];
         load_start   = (i == start_at);
         if (bus.rx_ready === 1'b1) acc_cyc.push_back(cyc + 1);
         else                       n_drop++;
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      load_start   = 1'b0;
      repeat (2) @(negedge clk);
      $display("load: bytes=%0d accepted=%0d dropped=%0d writes=%0d done=%b err=%b",
               frame.size(), acc_cyc.size(), n_drop, wr_addr.size(), load_done, load_error);
   endtask

   // Scoreboard: word k must land at BASE+4k one cycle after its 4th byte.
   function automatic int write_mismatches();
      int bad;
      int ec;
      bad = 0;
      if (wr_addr.size() != exp_words.size()) begin
         $display("  write count %0d, model %0d", wr_addr.size(), exp_words.size());
         return 1 + exp_words.size();
      end
      foreach (exp_words[k]) begin
         ec = (4*k + 5 < acc_cyc.size()) ? acc_cyc[4*k + 5] : -1;
         if (wr_addr[k] !== BASE + 32'(4*k) || wr_data[k] !== exp_words[k] || wr_cyc[k] != ec) begin
            bad++;
            $display("  write %0d: addr %h/%h data %h/%h cyc %0d/%0d", k, wr_addr[k],
                     BASE + 32'(4*k), wr_data[k], exp_words[k], wr_cyc[k], ec);
         end
      end
      return bad;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.rx_ready, bus.imem_we, cpu_hold, load_busy, load_done, load_error} !== 6'b001000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 001000",
                  {bus.rx_ready, bus.imem_we, cpu_hold, load_busy, load_done, load_error});
      end
      n_checks++;
      if (bus.imem_waddr !== BASE || bus.imem_wdata !== 32'h0 || words_written !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got addr %h data %h words %0d required %h 0 0",
                  bus.imem_waddr, bus.imem_wdata, words_written, BASE);
      end
      rst = 1'b0;
      // Bytes offered in IDLE without a start must be refused.
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h5A;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.rx_ready !== 1'b0 || load_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_accept: got ready %b busy %b required 0 0", bus.rx_ready, load_busy);
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic test_good_frame();
      int m;
      exp_words = '{32'h0050_0013, 32'h00A0_0093};
      // The checksum covers the length bytes too, so this frame ends in 0x72.
      build_frame(2, 1'b0);
      do_start();
      n_checks++;
      if (load_busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: got busy %b ready %b required 1 1", load_busy, bus.rx_ready);
      end
      send_frame(0, -1);
      m = write_mismatches();
      n_checks++;
      if (m != 0) begin
         n_fail++;
         $display("FAIL good_writes: got %0d bad writes required 0", m);
      end
      n_checks++;
      if ({load_done, load_error, cpu_hold, load_busy, bus.rx_ready} !== 5'b10000 || words_written !== 9'd2) begin
         n_fail++;
         $display("FAIL good_status: got done/err/hold/busy/ready %b words %0d required 10000 2",
                  {load_done, load_error, cpu_hold, load_busy, bus.rx_ready}, words_written);
      end
   endtask

   task automatic test_bad_csum();
      int m;
      exp_words = '{32'h0050_0013, 32'h00A0_0093};
      build_frame(2, 1'b0);
      frame[frame.size() - 1] = 8'h71;
      do_start();
      send_frame(0, -1);
      m = write_mismatches();
      n_checks++;
      if (m != 0) begin
         n_fail++;
         $display("FAIL badcsum_writes: got %0d bad writes required 0", m);
      end
      n_checks++;
      if ({load_done, load_error, cpu_hold} !== 3'b011 || words_written !== 9'd2) begin
         n_fail++;
         $display("FAIL badcsum_status: got done/err/hold %b words %0d required 011 2",
                  {load_done, load_error, cpu_hold}, words_written);
      end
   endtask

   task automatic test_too_long();
      exp_words.delete();
      build_frame(257, 1'b0);
      for (int i = 0; i < 4; i++) frame.push_back(8'($urandom));
      do_start();
      send_frame(0, -1);
      n_checks++;
      if (acc_cyc.size() != 2 || n_drop != frame.size() - 2) begin
         n_fail++;
         $display("FAIL toolong_accept: got accepted %0d dropped %0d required 2 %0d",
                  acc_cyc.size(), n_drop, frame.size() - 2);
      end
      n_checks++;
      if (wr_addr.size() != 0 || load_error !== 1'b1 || bus.rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL toolong_status: got writes %0d err %b ready %b hold %b required 0 1 0 1",
                  wr_addr.size(), load_error, bus.rx_ready, cpu_hold);
      end
   endtask

   task automatic test_zero_and_max();
      int m;
      exp_words.delete();
      build_frame(0, 1'b0);
      do_start();
      send_frame(0, -1);
      n_checks++;
      if (wr_addr.size() != 0 || load_done !== 1'b1 || words_written !== 9'd0) begin
         n_fail++;
         $display("FAIL zero_len: got writes %0d done %b words %0d required 0 1 0",
                  wr_addr.size(), load_done, words_written);
      end
      random_words(DEPTH);
      build_frame(DEPTH, 1'b0);
      do_start();
      send_frame(0, -1);
      m = write_mismatches();
      n_checks++;
      if (m != 0) begin
         n_fail++;
         $display("FAIL max_writes: got %0d bad writes required 0", m);
      end
      n_checks++;
      if (wr_addr.size() == 0 || wr_addr[$] !== 32'h0000_03FC || words_written !== 9'd256 || load_done !== 1'b1) begin
         n_fail++;
         $display("FAIL max_last: got last addr %h words %0d done %b required 3fc 256 1",
                  (wr_addr.size() != 0) ? wr_addr[$] : 32'hx, words_written, load_done);
      end
   endtask

   task automatic test_gaps();
      int m;
      exp_words = '{32'h0050_0013, 32'h00A0_0093};
      build_frame(2, 1'b0);
      do_start();
      send_frame(50, -1);
      m = write_mismatches();
      n_checks++;
      if (m != 0 || load_done !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps: got %0d bad writes done %b required 0 1", m, load_done);
      end
   endtask

   task automatic test_start_while_busy();
      int m;
      random_words(3);
      build_frame(3, 1'b0);
      do_start();
      send_frame(20, 5);
      m = write_mismatches();
      n_checks++;
      if (m != 0 || load_done !== 1'b1 || words_written !== 9'd3) begin
         n_fail++;
         $display("FAIL start_busy_ignored: got %0d bad writes done %b words %0d required 0 1 3",
                  m, load_done, words_written);
      end
   endtask

   task automatic test_random();
      int  m;
      int  n;
      bit  bad;
      for (int it = 0; it < 6; it++) begin
         n   = $urandom_range(1, 6);
         bad = 1'($urandom_range(0, 1));
         random_words(n);
         build_frame(n, bad);
         do_start();
         send_frame(30, -1);
         m = write_mismatches();
         n_checks++;
         if (m != 0 || load_done !== !bad || load_error !== bad || words_written !== 9'(n)) begin
            n_fail++;
            $display("FAIL random_%0d: got %0d bad writes done %b err %b words %0d required 0 %b %b %0d",
                     it, m, load_done, load_error, words_written, !bad, bad, n);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int m;
      random_words(2);
      exp_words[0] = exp_words[0] | 32'h1;
      build_frame(2, 1'b0);
      frame = frame[0:6];
      do_start();
      send_frame(0, -1);
      n_checks++;
      if (words_written !== 9'd1 || load_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_pre: got words %0d busy %b required 1 1", words_written, load_busy);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.rx_ready, bus.imem_we, cpu_hold, load_busy, load_done, load_error} !== 6'b001000 ||
          bus.imem_waddr !== BASE || bus.imem_wdata !== 32'h0 || words_written !== 9'd0) begin
         n_fail++;
         $display("FAIL midframe_reset: got flags %b addr %h data %h words %0d required 001000 %h 0 0",
                  {bus.rx_ready, bus.imem_we, cpu_hold, load_busy, load_done, load_error},
                  bus.imem_waddr, bus.imem_wdata, words_written, BASE);
      end
      @(negedge clk);
      rst = 1'b0;
      random_words(4);
      build_frame(4, 1'b0);
      do_start();
      send_frame(10, -1);
      m = write_mismatches();
      n_checks++;
      if (m != 0 || load_done !== 1'b1 || words_written !== 9'd4) begin
         n_fail++;
         $display("FAIL reload_after_reset: got %0d bad writes done %b words %0d required 0 1 4",
                  m, load_done, words_written);
      end
   endtask

   initial begin
      rst          = 1'b1;
      load_start   = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_too_long();
      test_zero_and_max();
      test_gaps();
      test_start_while_busy();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
